char_row_buffer: RTL

Parametrised text-row buffer for the VGA character overlay. Holds one row of COLS character codes, written through a cursor-based port, and read out by the pixel scan: for every (xcoor, ycoor) it returns the character code under the beam plus the pixel offset inside the glyph, two cycles later, for the downstream glyph ROM. Sits between the host command decoder (write side) and the glyph/pixel generator (scan side). It adds a hardware clear sweep and an auto-incrementing cursor.

---
 rtl/char_row_buffer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/char_row_buffer.sv
// One text row of character codes for the VGA overlay: cursor-driven write port,
// hardware clear sweep, and a two-stage scan pipeline feeding the glyph ROM.
module char_row_buffer #(
  parameter int                   COLS      = 32,
  parameter int                   CHAR_BITS = 6,
  parameter int                   CHAR_W    = 8,
  parameter int                   CHAR_H    = 10,
  parameter int                   X_START   = 0,
  parameter int                   Y_START   = 100,
  parameter logic [CHAR_BITS-1:0] BLANK     = '1,
  localparam int                  AW        = $clog2(COLS),
  localparam int                  CW        = $clog2(CHAR_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           xcoor,
  input  logic [8:0]           ycoor,
  input  logic                 wr_en,
  input  logic [CHAR_BITS-1:0] wr_data,
  input  logic                 wr_addr_load,
  input  logic [AW-1:0]        wr_addr,
  input  logic                 clear_start,
  output logic                 busy,
  output logic [AW-1:0]        cursor,
  output logic [CHAR_BITS-1:0] char_out,
  output logic [CW-1:0]        glyph_col,
  output logic [3:0]           glyph_row,
  output logic                 in_row
);

  localparam logic [AW-1:0] LAST   = AW'(COLS - 1);
  localparam logic [10:0]   X_LO   = 11'(X_START);
  localparam logic [10:0]   X_SPAN = 11'(COLS * CHAR_W);
  localparam logic [9:0]    Y_LO   = 10'(Y_START);
  localparam logic [9:0]    Y_SPAN = 10'(CHAR_H);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic [AW-1:0]        cursor_q, cursor_d;
  logic [AW-1:0]        wr_base;
  logic                 mem_we;
  logic [AW-1:0]        mem_waddr;
  logic [CHAR_BITS-1:0] mem_wdata;
  logic [CHAR_BITS-1:0] mem [COLS];

  // Scan stage 1
  logic [10:0]          x_off;
  logic [9:0]           y_off;
  logic                 win_q, win_d;
  logic [AW-1:0]        col_q, col_d;
  logic [CW-1:0]        gcol_q, gcol_d;
  logic [3:0]           grow_q, grow_d;

  // Scan stage 2
  logic                 in_row_q, in_row_d;
  logic                 sel_q, sel_d;
  logic [CW-1:0]        glyph_col_q, glyph_col_d;
  logic [3:0]           glyph_row_q, glyph_row_d;
  logic [CHAR_BITS-1:0] rd_q;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    return (a == LAST) ? '0 : a + AW'(1);
  endfunction

  // wr_addr has fewer than 2*COLS codes, so one conditional subtract is a full modulo
  function automatic logic [AW-1:0] mod_cols(input logic [AW-1:0] a);
    return (a > LAST) ? a - AW'(COLS) : a;
  endfunction

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cursor_d  = cursor_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = BLANK;
    wr_base   = wr_addr_load ? mod_cols(wr_addr) : cursor_q;
    if (state_q == ST_CLEAR) begin
      mem_we = 1'b1;
      ptr_d  = wrap_inc(ptr_q);
      if (ptr_q == LAST) begin
        state_d = ST_IDLE;
      end
      if (wr_addr_load) begin
        cursor_d = mod_cols(wr_addr);
      end
    end else begin
      if (clear_start) begin
        state_d  = ST_CLEAR;
        ptr_d    = '0;
        cursor_d = '0;
      end else if (wr_en) begin
        mem_we    = 1'b1;
        mem_waddr = wr_base;
        mem_wdata = wr_data;
        cursor_d  = wrap_inc(wr_base);
      end else begin
        cursor_d = wr_base;
      end
    end
  end

  // Out-of-window coordinates underflow to large offsets, so one unsigned compare per axis suffices
  always_comb begin
    x_off       = {1'b0, xcoor} - X_LO;
    y_off       = {1'b0, ycoor} - Y_LO;
    win_d       = (x_off < X_SPAN) && (y_off < Y_SPAN);
    col_d       = win_d ? x_off[CW +: AW] : '0;
    gcol_d      = win_d ? x_off[CW-1:0] : '0;
    grow_d      = win_d ? y_off[3:0] : '0;
    in_row_d    = win_q;
    sel_d       = win_q && (state_q == ST_IDLE);
    glyph_col_d = gcol_q;
    glyph_row_d = grow_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      cursor_q    <= '0;
      win_q       <= 1'b0;
      col_q       <= '0;
      gcol_q      <= '0;
      grow_q      <= '0;
      in_row_q    <= 1'b0;
      sel_q       <= 1'b0;
      glyph_col_q <= '0;
      glyph_row_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cursor_q    <= cursor_d;
      win_q       <= win_d;
      col_q       <= col_d;
      gcol_q      <= gcol_d;
      grow_q      <= grow_d;
      in_row_q    <= in_row_d;
      sel_q       <= sel_d;
      glyph_col_q <= glyph_col_d;
      glyph_row_q <= glyph_row_d;
    end
  end

  // Unreset RAM with registered read; same-entry write lands after the read (old value returned)
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_q <= mem[col_q];
  end

  assign busy      = (state_q == ST_CLEAR);
  assign cursor    = cursor_q;
  assign char_out  = sel_q ? rd_q : BLANK;
  assign glyph_col = glyph_col_q;
  assign glyph_row = glyph_row_q;
  assign in_row    = in_row_q;

endmodule
